// File: rtl/instr_queue.sv
// Instruction prefetch FIFO with a combinational MIPS field decode of the head word.
// Define INSTR_QUEUE_BYPASS_EN to let a word pushed into an empty queue appear at the head in the same cycle.
module instr_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [31:0]                memdata,
  output logic                       push_ready,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       head_valid,
  output logic [31:0]                instr,
  output logic [5:0]                 opcode,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [15:0]                imm16,
  output logic [25:0]                target26,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          empty;
  logic          bypass;
  logic          push_acc;
  logic          pop_acc;
  logic [31:0]   head_word;

  assign empty      = (count_reg == '0);
  assign push_ready = (count_reg != FULL);
  assign count      = count_reg;

`ifdef INSTR_QUEUE_BYPASS_EN
  assign bypass = empty && push && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that is popped in the same cycle never enters storage.
  assign push_acc = push && push_ready && !flush && !(bypass && pop);
  assign pop_acc  = pop && !empty && !flush;

  always_comb begin
    count_next = count_reg;
    case ({push_acc, pop_acc})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else if (flush) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      count_reg <= count_next;
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_acc)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_reg] <= memdata;
  end

  assign head_valid = !empty || bypass;
  assign head_word  = bypass ? memdata : mem[rd_ptr_reg];
  assign instr      = head_valid ? head_word : 32'd0;

  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];
  assign target26 = instr[25:0];

endmodule
